// File: rtl/cia_sp_pkg.sv
// rtl/cia_sp_pkg.sv - shared types and constants for the CIA serial port link
package cia_sp_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_HIGH,
      TX_LOW,
      TX_GAP
   } tx_state_t;

   localparam int   BIT_CNT_W = 3;
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/cia_sp_sync.sv
// rtl/cia_sp_sync.sv - two-flop line synchroniser with rising-edge detect
module cia_sp_sync
   import cia_sp_pkg::*;
(
   input  logic clk,
   input  logic res_n,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [1:0] meta;
   logic       q_d;

   // Lines idle high, so reset to high to avoid a false rise after reset
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         meta <= {2{LINE_IDLE}};
         q_d  <= LINE_IDLE;
      end else begin
         meta <= {meta[0], d};
         q_d  <= meta[1];
      end
   end

   assign q    = meta[1];
   assign rise = meta[1] & ~q_d;

endmodule

// File: rtl/cia_sp_link.sv
// rtl/cia_sp_link.sv - CIA CNT/SP remote-end transceiver; SP_RX_TIMEOUT_EN drops stale partial bytes
module cia_sp_link
   import cia_sp_pkg::*;
#(
   parameter int HALF    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ce,
   input  logic       drive_en,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       cnt_in,
   input  logic       sp_in,
   output logic       cnt_out,
   output logic       sp_out,
   output logic       busy
);

   localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [TW-1:0]        TICK_LAST = TW'(HALF - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = '1;

   tx_state_t             state, state_d;
   logic [TW-1:0]         tick, tick_d;
   logic [7:0]            tx_sh, tx_sh_d;
   logic [BIT_CNT_W-1:0]  tx_bits, tx_bits_d;

   logic                  cnt_s_unused, cnt_rise, sp_s, sp_rise_unused;
   logic                  drive_en_q, rx_en, rx_timeout;
   logic [BIT_CNT_W-1:0]  rx_bits;
   logic [7:0]            rx_sh;

   cia_sp_sync u_cnt_sync (.clk(clk), .res_n(res_n), .d(cnt_in), .q(cnt_s_unused), .rise(cnt_rise));
   cia_sp_sync u_sp_sync  (.clk(clk), .res_n(res_n), .d(sp_in),  .q(sp_s),         .rise(sp_rise_unused));

   assign tx_ready = res_n & drive_en & (state == TX_IDLE);
   assign busy     = (state != TX_IDLE) | (rx_bits != '0);

   // TX state, tick, shift and bit counters
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state   <= TX_IDLE;
         tick    <= '0;
         tx_sh   <= '0;
         tx_bits <= '0;
      end else begin
         state   <= state_d;
         tick    <= tick_d;
         tx_sh   <= tx_sh_d;
         tx_bits <= tx_bits_d;
      end
   end

   // TX next state and CNT/SP drive; dropping drive_en aborts the byte
   always_comb begin
      state_d   = state;
      tick_d    = tick;
      tx_sh_d   = tx_sh;
      tx_bits_d = tx_bits;
      cnt_out   = LINE_IDLE;
      sp_out    = LINE_IDLE;
      case (state)
         TX_IDLE: begin
            if (tx_valid && tx_ready) begin
               state_d   = TX_HIGH;
               tx_sh_d   = tx_data;
               tick_d    = '0;
               tx_bits_d = '0;
            end
         end
         TX_HIGH: begin
            sp_out = tx_sh[7];
            if (ce) begin
               if (tick == TICK_LAST) begin
                  state_d = TX_LOW;
                  tick_d  = '0;
               end else begin
                  tick_d = tick + TW'(1);
               end
            end
         end
         TX_LOW: begin
            cnt_out = 1'b0;
            sp_out  = tx_sh[7];
            if (ce) begin
               if (tick == TICK_LAST) begin
                  tick_d    = '0;
                  tx_bits_d = tx_bits + 1'b1;
                  if (tx_bits == BIT_LAST) begin
                     state_d = TX_GAP;
                  end else begin
                     tx_sh_d = {tx_sh[6:0], 1'b0};
                     state_d = TX_HIGH;
                  end
               end else begin
                  tick_d = tick + TW'(1);
               end
            end
         end
         TX_GAP: begin
            if (ce) begin
               if (tick == TICK_LAST) begin
                  state_d = TX_IDLE;
                  tick_d  = '0;
               end else begin
                  tick_d = tick + TW'(1);
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
      if (!drive_en && state != TX_IDLE) begin
         state_d   = TX_IDLE;
         tick_d    = '0;
         tx_bits_d = '0;
      end
   end

   // A rise in the same clk as drive_en falling is ignored
   assign rx_en = ~drive_en & ~drive_en_q;

   // RX deserialiser, MSB first, byte completes on the 8th CNT rise
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         drive_en_q <= 1'b0;
         rx_bits    <= '0;
         rx_sh      <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
      end else begin
         drive_en_q <= drive_en;
         rx_valid   <= 1'b0;
         if (drive_en) begin
            rx_bits <= '0;
         end else if (rx_en && cnt_rise) begin
            rx_sh   <= {rx_sh[6:0], sp_s};
            rx_bits <= rx_bits + 1'b1;
            if (rx_bits == BIT_LAST) begin
               rx_data  <= {rx_sh[6:0], sp_s};
               rx_valid <= 1'b1;
            end
         end else if (rx_timeout) begin
            rx_bits <= '0;
            rx_sh   <= '0;
         end
      end
   end

`ifdef SP_RX_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_cnt;

   assign rx_timeout = (idle_cnt == IW'(TIMEOUT));

   // Counts ce ticks since the last CNT rise while a byte is partial
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         idle_cnt <= '0;
      end else if (drive_en || rx_bits == '0 || (rx_en && cnt_rise) || rx_timeout) begin
         idle_cnt <= '0;
      end else if (ce) begin
         idle_cnt <= idle_cnt + IW'(1);
      end
   end
`else
   assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cia_sp_link.sv
// tb/tb_cia_sp_link.sv - self-checking bench for cia_sp_link
`timescale 1ns/1ps
module tb_cia_sp_link;

   localparam int HALF    = 4;
   localparam int TIMEOUT = 64;

   logic       clk = 1'b0, res_n = 1'b0, ce = 1'b1, drive_en = 1'b1;
   logic       tx_valid = 1'b0, cnt_in = 1'b1, sp_in = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, rx_valid, cnt_out, sp_out, busy;
   logic [7:0] rx_data;

   int         tests = 0, fails = 0;
   logic       ce_rand = 1'b0;

   logic [7:0] cia_sr = 8'h00;
   int         cia_n = 0, rise_n = 0;
   logic [7:0] cia_q[$];
   time        fall_t[$];
   time        rdy_t = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic       is_tx;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[4];

   cia_sp_link #(.HALF(HALF), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .res_n(res_n), .ce(ce), .drive_en(drive_en),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .cnt_in(cnt_in), .sp_in(sp_in), .cnt_out(cnt_out), .sp_out(sp_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      ce = ce_rand ? 1'($urandom_range(1)) : 1'b1;
   end

   // CIA in input mode: samples SP on each CNT falling edge, MSB first
   always @(negedge cnt_out) begin
      fall_t.push_back($time);
      #1;
      cia_sr = {cia_sr[6:0], sp_out};
      cia_n++;
      if (cia_n == 8) begin
         cia_q.push_back(cia_sr);
         cia_n = 0;
      end
   end

   always @(posedge cnt_out) rise_n++;
   always @(posedge tx_ready) rdy_t = $time;
   always @(negedge clk) if (rx_valid) rx_q.push_back(rx_data);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tx_send(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_wait", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_drop", tx_ready, 0);
   endtask

   task automatic wait_tx_idle();
      int n = 0;
      while (!(tx_ready && !busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("tx_idle_wait", n < 3000, 1);
   endtask

   // CIA in output mode: SP changes with CNT falling, stable across the rise
   task automatic rx_send(input logic [7:0] b, input int msb, input int nbits, input int half);
      for (int k = 0; k < nbits; k++) begin
         cnt_in = 1'b0;
         sp_in  = b[msb-k];
         repeat (half) @(negedge clk);
         cnt_in = 1'b1;
         repeat (half) @(negedge clk);
      end
      sp_in = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic rx_byte_check(input string name, input logic [7:0] b, input int half);
      rx_q.delete();
      rx_send(b, 7, 8, half);
      check({name, "_count"}, rx_q.size(), 1);
      check({name, "_data"}, (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
      check({name, "_busy"}, busy, 0);
   endtask

   initial begin
      int n;
      logic [7:0] b;
      int half;

      vecs[0] = '{1'b1, 8'hA5, 8'hA5};
      vecs[1] = '{1'b0, 8'h3C, 8'h3C};
      vecs[2] = '{1'b1, 8'h5A, 8'h5A};
      vecs[3] = '{1'b0, 8'hE7, 8'hE7};

      // reset values
      repeat (3) @(negedge clk);
      check("rst_cnt_out", cnt_out, 1);
      check("rst_sp_out", sp_out, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      res_n = 1'b1;
      @(negedge clk);
      check("rel_tx_ready", tx_ready, 1);

      // table-driven bytes, ce every clk
      foreach (vecs[i]) begin
         if (vecs[i].is_tx) begin
            drive_en = 1'b1;
            @(negedge clk);
            cia_q.delete(); fall_t.delete(); cia_n = 0;
            tx_send(vecs[i].data);
            wait_tx_idle();
            check("vec_tx_count", cia_q.size(), 1);
            check("vec_tx_data", (cia_q.size() > 0) ? cia_q[0] : 8'hxx, vecs[i].exp);
            check("vec_tx_falls", fall_t.size(), 8);
            if (fall_t.size() == 8) begin
               for (int j = 1; j < 8; j++)
                  check("vec_tx_fall_spacing", int'(fall_t[j] - fall_t[j-1]), 2 * HALF * 10);
               check("vec_tx_ready_after_gap", int'(rdy_t - fall_t[7]), 2 * HALF * 10);
            end
         end else begin
            drive_en = 1'b0;
            repeat (2) @(negedge clk);
            rx_byte_check("vec_rx", vecs[i].exp, 4);
         end
      end

      // back-to-back with tx_valid held
      drive_en = 1'b1;
      @(negedge clk);
      cia_q.delete(); fall_t.delete(); cia_n = 0; rise_n = 0;
      tx_data = 8'h01; tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hFF;
      n = 0;
      while (cia_q.size() < 2 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      wait_tx_idle();
      check("b2b_count", cia_q.size(), 2);
      check("b2b_byte0", (cia_q.size() > 0) ? cia_q[0] : 8'hxx, 8'h01);
      check("b2b_byte1", (cia_q.size() > 1) ? cia_q[1] : 8'hxx, 8'hFF);
      check("b2b_falls", fall_t.size(), 16);
      check("b2b_rises", rise_n, 16);
      if (fall_t.size() == 16)
         check("b2b_gap_spacing", int'(fall_t[8] - fall_t[7]), (3 * HALF + 1) * 10);

      // abort after 3 bits, then receive
      cia_q.delete(); cia_n = 0;
      tx_send(8'hF0);
      n = 0;
      while (cia_n < 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      drive_en = 1'b0;
      @(negedge clk);
      check("abort_cnt_out", cnt_out, 1);
      check("abort_sp_out", sp_out, 1);
      check("abort_busy", busy, 0);
      repeat (20) @(negedge clk);
      check("abort_no_byte", cia_q.size(), 0);
      cia_n = 0;
      rx_byte_check("abort_rx", 8'h55, 4);

      // drive_en falling together with a synchronised CNT rise
      drive_en = 1'b1;
      cnt_in = 1'b0;
      repeat (4) @(negedge clk);
      cnt_in = 1'b1;
      repeat (2) @(negedge clk);
      drive_en = 1'b0;
      repeat (4) @(negedge clk);
      check("simul_rise_ignored", busy, 0);
      rx_byte_check("simul_rx", 8'h3C, 4);

      // async reset mid-byte
      rx_q.delete();
      rx_send(8'hAA, 7, 5, 4);
      check("mid_busy", busy, 1);
      #2 res_n = 1'b0;
      #1;
      check("mrst_cnt_out", cnt_out, 1);
      check("mrst_sp_out", sp_out, 1);
      check("mrst_tx_ready", tx_ready, 0);
      check("mrst_rx_data", rx_data, 8'h00);
      check("mrst_rx_valid", rx_valid, 0);
      check("mrst_busy", busy, 0);
      repeat (2) @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      check("mrst_no_partial", rx_q.size(), 0);
      rx_byte_check("mrst_rx", 8'h81, 4);

`ifdef SP_RX_TIMEOUT_EN
      rx_q.delete();
      rx_send(8'hF0, 7, 4, 4);
      check("to_partial_busy", busy, 1);
      repeat (TIMEOUT + 8) @(negedge clk);
      check("to_cleared", busy, 0);
      check("to_no_valid", rx_q.size(), 0);
      rx_byte_check("to_rx", 8'hC3, 4);
`else
      rx_q.delete();
      rx_send(8'hC3, 7, 4, 4);
      repeat (200) @(negedge clk);
      check("persist_busy", busy, 1);
      rx_send(8'hC3, 3, 4, 4);
      check("persist_count", rx_q.size(), 1);
      check("persist_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hC3);
`endif

      // randomised traffic against a byte-level reference
      ce_rand = 1'b1;
      for (int it = 0; it < 16; it++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         if ($urandom_range(1) == 1) begin
            drive_en = 1'b1;
            @(negedge clk);
            cia_q.delete(); cia_n = 0;
            tx_send(b);
            wait_tx_idle();
            check("rnd_tx_count", cia_q.size(), 1);
            check("rnd_tx_data", (cia_q.size() > 0) ? cia_q[0] : 8'hxx, exp_q.pop_front());
         end else begin
            drive_en = 1'b0;
            half = $urandom_range(6, 2);
            repeat (2) @(negedge clk);
            rx_q.delete();
            rx_send(b, 7, 8, half);
            check("rnd_rx_count", rx_q.size(), 1);
            check("rnd_rx_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, exp_q.pop_front());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cia_sp_link.md
Name: cia_sp_link

Overview:
- Remote-end transceiver for the CIA serial port (CNT/SP pair), for peripheral models such as a fast-serial drive or link cable.
- Receive side: deserialises bytes that a CIA in output mode shifts out on CNT/SP.
- Transmit side: generates CNT clock and SP data so that a CIA in input mode receives a byte.
- Half duplex. The link drives CNT/SP only while `drive_en`=1.

Parameters:
- HALF, 4: number of ce ticks per CNT half-period when transmitting. Minimum 1.
- TIMEOUT, 64: number of ce ticks without a CNT rising edge before a partial receive byte is discarded. Used only with SP_RX_TIMEOUT_EN.

Ports:
- `clk` input 1: system clock.
- `res_n` input 1: reset, asynchronous, active-low.
- `ce` input 1: cycle enable, one clk pulse per bus cycle (wired to phi2_p).
- `drive_en` input 1: 1 = link drives CNT/SP (transmit direction); 0 = link listens.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: tx_data is valid.
- `tx_ready` output 1: link can accept a byte.
- `rx_data` output 8: last received byte.
- `rx_valid` output 1: one-clk pulse when rx_data is updated.
- `cnt_in` input 1: CNT line as seen from the bus.
- `sp_in` input 1: SP line as seen from the bus.
- `cnt_out` output 1: CNT drive value. Idle is high.
- `sp_out` output 1: SP drive value. Idle is high.
- `busy` output 1: transmit or receive byte in progress.

Behaviour:
- Reset (async):
  - Outputs: `cnt_out`=1, `sp_out`=1, `tx_ready`=0 while `res_n` is low and 1 after release, `rx_data`=8'h00, `rx_valid`=0, `busy`=0.
  - TX FSM goes to IDLE; bit counters are cleared.
  - Reset mid-byte aborts the transfer with no partial rx_valid.
- Input sync: `cnt_in` and `sp_in` pass through 2-flop synchronisers on every clk (not ce-gated). A rise is detected when the synchronised CNT goes 0→1 between consecutive clks.
- TX handshake:
  - A byte is accepted on a clk where `tx_valid`&`tx_ready`. It is latched into the shift register and `tx_ready` drops the next clk.
  - `tx_ready`=1 only in IDLE with `drive_en`=1.
- TX FSM states: IDLE, HIGH, LOW, GAP. Tick counter counts ce pulses.
  - IDLE → HIGH on accept: `sp_out`=shreg[7] (MSB first), `cnt_out`=1, tick=0.
  - HIGH: on each ce, tick+1. When tick reaches HALF-1 at a ce, go to LOW with `cnt_out`=0. The CIA samples on this falling edge.
  - LOW: after HALF ce ticks, `cnt_out`=1.
    - If bits sent <7: shift left, drive the next bit, go to HIGH.
    - Otherwise go to GAP.
  - GAP: `sp_out`=1, `cnt_out`=1 for HALF ce ticks, then IDLE.
  - Bit counter is 3-bit and wraps after 8 bits.
  - Byte length is exactly 16·HALF ce ticks from entering HIGH to entering GAP.
- `drive_en`=0 while not in IDLE: abort, return to IDLE with `cnt_out`=`sp_out`=1 on the next clk. The byte is dropped.
- RX (active only when `drive_en`=0):
  - On each synchronised CNT rise: shift = {shift[6:0], sp_sync}, bit count +1.
  - On the 8th rise, in the same clk: `rx_data` ← new shift value, `rx_valid`=1 for one clk, count ← 0.
  - RX counter is held cleared while `drive_en`=1.
- `busy` = (TX state≠IDLE) | (RX count≠0).
- Simultaneous `drive_en` 1→0 and a CNT rise: the rise is ignored. RX starts counting from the next rise.

Optional Feature:
- SP_RX_TIMEOUT_EN defined: an idle counter advances on each ce while RX count≠0 and is cleared on each CNT rise. On reaching TIMEOUT, RX count and shift are cleared silently (no rx_valid).
- Not defined: a partial byte persists indefinitely until 8 rises complete it.

Decomposition:
- Package cia_sp_pkg: TX state enum (IDLE/HIGH/LOW/GAP), bit-count width constant (3), idle line level constant (1'b1).
- One natural sub-module: cia_sp_sync, the 2-flop synchroniser plus rise detector, instantiated for CNT (SP uses the sync only).

Test Plan:
- TX 8'hA5, HALF=4, ce every clk, `drive_en`=1:
  - 8 CNT falling edges, spaced 8 ce apart.
  - SP at each fall = 1,0,1,0,0,1,0,1.
  - `tx_ready` returns after GAP.
  - A reference CIA input model captures SDR=8'hA5.
- RX: `drive_en`=0, CIA-model drives 8'h3C (SP changes on CNT fall, sampled on rise) → exactly one `rx_valid` pulse, `rx_data`=8'h3C, `busy`=0 afterwards.
- Back-to-back TX 8'h01 then 8'hFF with `tx_valid` held high → second accepted the clk after GAP ends; both bytes received intact; no glitch on `cnt_out` between bytes.
- Abort: `drive_en` 1→0 after 3 bits of 8'hF0 → `cnt_out`=`sp_out`=1 next clk, FSM IDLE; then RX of 8'h55 completes correctly.
- Async reset asserted mid-RX after 5 rises → all outputs at reset values immediately; after release, RX of 8'h81 yields `rx_data`=8'h81, not a merged value.
- SP_RX_TIMEOUT_EN, TIMEOUT=64:
  - 4 rises, then 64 idle ce → counter cleared, no `rx_valid`.
  - A subsequent full byte 8'hC3 is received as 8'hC3.
